// File: rtl/rpn_calculator.sv
// rpn_calculator: 8-bit RPN calculator with a RAM-backed operand stack and 7-segment display.
// Optional macro RPN_MUL_EN enables opcode 11 as A*B (low 8 bits); otherwise that opcode is an error.
module rpn_stack_ram #(
  parameter int DEPTH = 32,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] a,
  input  logic [7:0]    wd,
  output logic [7:0]    rd
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[a] <= wd;
    rd <= mem[a];
  end
endmodule

module rpn_calculator #(
  parameter int DEPTH = 32
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] ONE = AW'(1);
  localparam logic [AW-1:0] TOP = AW'(DEPTH - 1);

  typedef enum logic [3:0] {
    IDLE, WRITE, OPERATE_1, OPERATE_2, OPERATE_3, OPERATE_4, MATH_0, OPERATE_5, ERROR
  } state_t;

  state_t state, state_next;
  logic [AW-1:0] addr, ram_addr;
  logic empty, k1, k2, press, ram_we, full, two, illegal;
  logic [7:0] tos, opnd, a, b, r, alu, ram_wd, ram_rd, count;
  logic [1:0] op;
  logic rst_n;
  logic unused;

  assign rst_n = KEY[3];
  assign unused = &{1'b0, KEY[2:1], SW[8]};
  assign press = k2 & ~k1;
  assign full = !empty && addr == TOP;
  assign two = !empty && addr >= ONE;

`ifdef RPN_MUL_EN
  assign illegal = 1'b0;
  assign alu = op == 2'd0 ? a + b : op == 2'd1 ? a - b : op == 2'd2 ? a & b : 8'(a * b);
`else
  assign illegal = SW[1:0] == 2'b11;
  assign alu = op == 2'd0 ? a + b : op == 2'd1 ? a - b : a & b;
`endif

  rpn_stack_ram #(.DEPTH(DEPTH)) STACK (
    .clk(CLOCK_50),
    .we (ram_we),
    .a  (ram_addr),
    .wd (ram_wd),
    .rd (ram_rd)
  );

  always_comb begin
    state_next = state;
    ram_we = 1'b0;
    ram_addr = addr;
    ram_wd = opnd;
    case (state)
      IDLE:
        if (press)
          state_next = !SW[9] ? (full ? ERROR : WRITE) : (!two || illegal ? ERROR : OPERATE_1);
      WRITE: begin
        ram_we = 1'b1;
        ram_addr = empty ? '0 : addr + ONE;
        state_next = IDLE;
      end
      OPERATE_1: state_next = OPERATE_2;
      OPERATE_2: state_next = OPERATE_3;
      OPERATE_3: begin
        ram_addr = addr - ONE;
        state_next = OPERATE_4;
      end
      OPERATE_4: begin
        ram_addr = addr - ONE;
        state_next = MATH_0;
      end
      MATH_0: state_next = OPERATE_5;
      OPERATE_5: begin
        ram_we = 1'b1;
        ram_addr = addr - ONE;
        ram_wd = r;
        state_next = IDLE;
      end
      ERROR: if (press) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      empty <= 1'b1;
      tos <= '0;
      k1 <= 1'b1;
      k2 <= 1'b1;
      opnd <= '0;
      op <= '0;
      a <= '0;
      b <= '0;
      r <= '0;
    end else begin
      k1 <= KEY[0];
      k2 <= k1;
      state <= state_next;
      if (state == IDLE && press) begin
        opnd <= SW[7:0];
        op <= SW[1:0];
      end
      if (state == OPERATE_2) b <= ram_rd;
      if (state == OPERATE_4) a <= ram_rd;
      if (state == MATH_0) r <= alu;
      if (state == WRITE) begin
        addr <= empty ? addr : addr + ONE;
        empty <= 1'b0;
        tos <= opnd;
      end
      if (state == OPERATE_5) begin
        addr <= addr - ONE;
        tos <= r;
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  assign count = empty ? 8'd0 : 8'(addr) + 8'd1;
  assign LEDR = {state == ERROR, empty, empty ? 8'd0 : tos};
  assign HEX0 = empty ? 7'h7F : seg7(tos[3:0]);
  assign HEX1 = empty ? 7'h7F : seg7(tos[7:4]);
  assign HEX2 = seg7(SW[3:0]);
  assign HEX3 = seg7(SW[7:4]);
  assign HEX4 = seg7(count[3:0]);
  assign HEX5 = seg7(count[7:4]);
endmodule

// File: tb/tb_rpn_calculator.sv
// tb_rpn_calculator: randomized and directed checks of rpn_calculator against a queue-based stack model.
module tb_rpn_calculator;
  localparam int DEPTH = 32;
  logic clk = 1'b0;
  logic [3:0] key = 4'b0111;
  logic [9:0] sw = '0;
  logic [9:0] ledr;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] stk[$];
  logic [7:0] ramm [DEPTH];
  bit err = 0;

  rpn_calculator #(.DEPTH(DEPTH)) dut (
    .CLOCK_50(clk), .KEY(key), .SW(sw), .LEDR(ledr),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX4(hex4), .HEX5(hex5)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  function automatic logic [9:0] exp_ledr();
    return {err, stk.size() == 0, stk.size() == 0 ? 8'h00 : stk[stk.size()-1]};
  endfunction

  function automatic int exp_addr();
    return stk.size() == 0 ? 0 : stk.size() - 1;
  endfunction

  function automatic logic [7:0] calc(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
    int v;
    case (op)
      2'd0: v = x + y;
      2'd1: v = x - y;
      2'd2: v = x & y;
      default: v = x * y;
    endcase
    return v[7:0];
  endfunction

  task automatic model_press(input logic [9:0] s);
    logic [7:0] x, y;
    bit mul_ok;
`ifdef RPN_MUL_EN
    mul_ok = 1;
`else
    mul_ok = 0;
`endif
    if (err) err = 0;
    else if (!s[9]) begin
      if (stk.size() == DEPTH) err = 1;
      else begin
        stk.push_back(s[7:0]);
        ramm[stk.size()-1] = s[7:0];
      end
    end else if (stk.size() < 2 || (s[1:0] == 2'b11 && !mul_ok)) err = 1;
    else begin
      y = stk.pop_back();
      x = stk.pop_back();
      stk.push_back(calc(s[1:0], x, y));
      ramm[stk.size()-1] = stk[stk.size()-1];
    end
  endtask

  task automatic press(input logic [9:0] s);
    sw = s;
    @(negedge clk) key[0] = 1'b0;
    @(negedge clk) key[0] = 1'b1;
    repeat (12) @(negedge clk);
    model_press(s);
  endtask

  task automatic do_reset();
    @(negedge clk) key[3] = 1'b0;
    repeat (2) @(negedge clk);
    key[3] = 1'b1;
    repeat (2) @(negedge clk);
    stk.delete();
    err = 0;
  endtask

  task automatic test_reset();
    key = 4'b0111;
    repeat (4) @(negedge clk);
    n_cmp++; if (int'(dut.addr) !== 0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", dut.addr); end
    n_cmp++; if (ledr !== 10'h100) begin n_fail++; $display("FAIL reset_ledr got %h want 100", ledr); end
    n_cmp++; if (hex0 !== 7'h7F || hex1 !== 7'h7F) begin n_fail++; $display("FAIL reset_blank got %h %h want 7f 7f", hex1, hex0); end
    key[3] = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++; if (int'(dut.addr) !== 0 || ledr !== 10'h100) begin n_fail++; $display("FAIL idle_no_press got addr %0d ledr %h want 0 100", dut.addr, ledr); end
    n_cmp++; if (hex4 !== seg(4'h0)) begin n_fail++; $display("FAIL reset_count got %h want %h", hex4, seg(4'h0)); end
  endtask

  task automatic test_push();
    press(10'h0A9);
    n_cmp++; if (int'(dut.addr) !== 0 || dut.STACK.mem[0] !== 8'hA9) begin n_fail++; $display("FAIL push1 got addr %0d ram0 %h want 0 a9", dut.addr, dut.STACK.mem[0]); end
    n_cmp++; if (hex1 !== seg(4'hA) || hex0 !== seg(4'h9)) begin n_fail++; $display("FAIL push1_hex got %h %h want %h %h", hex1, hex0, seg(4'hA), seg(4'h9)); end
    n_cmp++; if (hex4 !== seg(4'h1) || ledr !== exp_ledr()) begin n_fail++; $display("FAIL push1_cnt got %h %h want %h %h", hex4, ledr, seg(4'h1), exp_ledr()); end
    press(10'h01B);
    n_cmp++; if (int'(dut.addr) !== 1 || dut.STACK.mem[0] !== 8'hA9 || dut.STACK.mem[1] !== 8'h1B) begin n_fail++; $display("FAIL push2 got addr %0d ram %h %h want 1 a9 1b", dut.addr, dut.STACK.mem[0], dut.STACK.mem[1]); end
    n_cmp++; if (hex3 !== seg(4'h1) || hex2 !== seg(4'hB)) begin n_fail++; $display("FAIL sw_hex got %h %h want %h %h", hex3, hex2, seg(4'h1), seg(4'hB)); end
  endtask

  task automatic test_add();
    press(10'h200);
    n_cmp++; if (int'(dut.addr) !== 0 || dut.STACK.mem[0] !== 8'hC4) begin n_fail++; $display("FAIL add got addr %0d ram0 %h want 0 c4", dut.addr, dut.STACK.mem[0]); end
    n_cmp++; if (ledr !== exp_ledr() || ledr[7:0] !== 8'hC4) begin n_fail++; $display("FAIL add_ledr got %h want %h", ledr, exp_ledr()); end
  endtask

  task automatic test_underflow();
    press(10'h200);
    n_cmp++; if (ledr !== exp_ledr() || !ledr[9]) begin n_fail++; $display("FAIL underflow got %h want %h", ledr, exp_ledr()); end
    n_cmp++; if (int'(dut.addr) !== 0 || dut.STACK.mem[0] !== 8'hC4) begin n_fail++; $display("FAIL underflow_stack got %0d %h want 0 c4", dut.addr, dut.STACK.mem[0]); end
    press(10'h200);
    n_cmp++; if (ledr !== exp_ledr() || ledr[9]) begin n_fail++; $display("FAIL err_clear got %h want %h", ledr, exp_ledr()); end
  endtask

  task automatic test_sub();
    do_reset();
    press(10'h005);
    press(10'h003);
    press(10'h201);
    n_cmp++; if (dut.STACK.mem[0] !== 8'h02 || ledr !== exp_ledr()) begin n_fail++; $display("FAIL sub got ram0 %h ledr %h want 02 %h", dut.STACK.mem[0], ledr, exp_ledr()); end
  endtask

  task automatic test_op11();
    press(10'h010);
    press(10'h010);
    press(10'h203);
    n_cmp++; if (ledr !== exp_ledr() || int'(dut.addr) !== exp_addr()) begin n_fail++; $display("FAIL op11 got ledr %h addr %0d want %h %0d", ledr, dut.addr, exp_ledr(), exp_addr()); end
    if (err) press(10'h000);
  endtask

  task automatic test_hold();
    sw = 10'h077;
    @(negedge clk) key[0] = 1'b0;
    repeat (10) @(negedge clk);
    key[0] = 1'b1;
    repeat (12) @(negedge clk);
    model_press(10'h077);
    n_cmp++; if (int'(dut.addr) !== exp_addr() || ledr !== exp_ledr()) begin n_fail++; $display("FAIL hold_no_repeat got addr %0d ledr %h want %0d %h", dut.addr, ledr, exp_addr(), exp_ledr()); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] lo, hi;
    int t;
    t = stk.size();
    lo = ramm[t-2];
    hi = ramm[t-1];
    sw = 10'h200;
    @(negedge clk) key[0] = 1'b0;
    @(negedge clk) key[0] = 1'b1;
    repeat (2) @(negedge clk);
    do_reset();
    repeat (10) @(negedge clk);
    n_cmp++; if (dut.STACK.mem[t-2] !== lo || dut.STACK.mem[t-1] !== hi) begin n_fail++; $display("FAIL reset_mid_ram got %h %h want %h %h", dut.STACK.mem[t-2], dut.STACK.mem[t-1], lo, hi); end
    n_cmp++; if (int'(dut.addr) !== 0 || ledr !== 10'h100) begin n_fail++; $display("FAIL reset_mid got addr %0d ledr %h want 0 100", dut.addr, ledr); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) press(10'($urandom_range(0, 255)));
    press(10'h055);
    n_cmp++; if (int'(dut.addr) !== DEPTH - 1 || !ledr[9] || ledr !== exp_ledr()) begin n_fail++; $display("FAIL full got addr %0d ledr %h want %0d %h", dut.addr, ledr, DEPTH - 1, exp_ledr()); end
    n_cmp++; if (hex5 !== seg(4'h2) || hex4 !== seg(4'h0)) begin n_fail++; $display("FAIL full_count got %h %h want %h %h", hex5, hex4, seg(4'h2), seg(4'h0)); end
    press(10'h000);
  endtask

  task automatic test_random();
    logic [9:0] s;
    logic [7:0] c;
    do_reset();
    for (int i = 0; i < 150; i++) begin
      s = 10'($urandom);
      s[9] = $urandom_range(0, 2) == 0;
      press(s);
      c = 8'(stk.size());
      n_cmp++; if (ledr !== exp_ledr() || int'(dut.addr) !== exp_addr()) begin n_fail++; $display("FAIL rand_%0d got ledr %h addr %0d want %h %0d", i, ledr, dut.addr, exp_ledr(), exp_addr()); end
      n_cmp++; if (hex4 !== seg(c[3:0]) || hex5 !== seg(c[7:4])) begin n_fail++; $display("FAIL rand_cnt_%0d got %h %h want %h %h", i, hex5, hex4, seg(c[7:4]), seg(c[3:0])); end
      if (stk.size() > 0) begin
        n_cmp++; if (dut.STACK.mem[stk.size()-1] !== ramm[stk.size()-1] || hex0 !== seg(stk[stk.size()-1][3:0]) || hex1 !== seg(stk[stk.size()-1][7:4])) begin n_fail++; $display("FAIL rand_top_%0d got ram %h hex %h %h want %h", i, dut.STACK.mem[stk.size()-1], hex1, hex0, ramm[stk.size()-1]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_push();
    test_add();
    test_underflow();
    test_sub();
    test_op11();
    test_hold();
    press(10'h0E7);
    test_reset_mid();
    test_full();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
